if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of decode/register-file read. Holds the program counter, reads a local word-addressed instruction memory, and drives the IF/ID pipeline register consumed by the decode stage. Supports hazard stalls, branch redirects and pipeline flushes from downstream stages, plus a write port so the testbench can preload programs.

---
 rtl/if_stage_if.sv | 32 +++
 rtl/if_stage.sv | 90 +++++++++
 tb/tb_if_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Bundle of the fetch-stage control, preload and IF/ID signals between the
// pipeline controller (master) and the fetch stage (slave).
interface if_stage_if #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned IMEM_DEPTH = 64
);
  logic                          stall_i;
  logic                          flush_i;
  logic                          branch_taken_i;
  logic [DATA_W-1:0]             branch_target_i;
  logic                          imem_we_i;
  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr_i;
  logic [DATA_W-1:0]             imem_wdata_i;
  logic [DATA_W-1:0]             pc_o;
  logic [DATA_W-1:0]             if_id_pc_o;
  logic [DATA_W-1:0]             if_id_pc_plus2_o;
  logic [DATA_W-1:0]             if_id_instr_o;
  logic                          if_id_valid_o;
  logic [15:0]                   fetch_count_o;

  modport master (
    output stall_i, flush_i, branch_taken_i, branch_target_i,
           imem_we_i, imem_waddr_i, imem_wdata_i,
    input  pc_o, if_id_pc_o, if_id_pc_plus2_o, if_id_instr_o, if_id_valid_o, fetch_count_o
  );

  modport slave (
    input  stall_i, flush_i, branch_taken_i, branch_target_i,
           imem_we_i, imem_waddr_i, imem_wdata_i,
    output pc_o, if_id_pc_o, if_id_pc_plus2_o, if_id_instr_o, if_id_valid_o, fetch_count_o
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, local word-addressed instruction memory
// and the IF/ID pipeline register, with stall, flush and branch redirect.
module if_stage #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       IMEM_DEPTH = 64,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR  = '0
) (
  input logic         clk,
  input logic         rst,
  if_stage_if.slave   bus
);
  localparam int unsigned       AW       = $clog2(IMEM_DEPTH);
  localparam logic [DATA_W-2:0] LP_DEPTH = (DATA_W-1)'(IMEM_DEPTH);

  logic [DATA_W-1:0] r_mem [IMEM_DEPTH];
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_if_pc;
  logic [DATA_W-1:0] r_if_pc2;
  logic [DATA_W-1:0] r_if_instr;
  logic              r_if_valid;
  logic [15:0]       r_fetch_cnt;

  logic [DATA_W-2:0] w_idx;
  logic              w_in_range;
  logic [DATA_W-1:0] w_instr;
  logic [DATA_W-1:0] w_pc_plus2;
  logic [DATA_W-1:0] w_target;

  assign w_idx      = r_pc[DATA_W-1:1];
  assign w_in_range = (w_idx < LP_DEPTH);
  assign w_instr    = w_in_range ? r_mem[w_idx[AW-1:0]] : NOP_INSTR;
  assign w_pc_plus2 = r_pc + DATA_W'(2);
  // Redirects are forced to halfword alignment.
  assign w_target   = bus.branch_target_i & ~DATA_W'(1);

  // Memory is deliberately not reset so a preloaded program survives rst.
  always_ff @(posedge clk) begin
    if (bus.imem_we_i) begin
      r_mem[bus.imem_waddr_i] <= bus.imem_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_if_pc     <= '0;
      r_if_pc2    <= '0;
      r_if_instr  <= NOP_INSTR;
      r_if_valid  <= 1'b0;
      r_fetch_cnt <= '0;
    end else if (bus.branch_taken_i) begin
      r_pc       <= w_target;
      r_if_pc    <= '0;
      r_if_pc2   <= '0;
      r_if_instr <= NOP_INSTR;
      r_if_valid <= 1'b0;
    end else if (bus.stall_i) begin
      // PC holds; a concurrent flush still squashes IF/ID.
      if (bus.flush_i) begin
        r_if_pc    <= '0;
        r_if_pc2   <= '0;
        r_if_instr <= NOP_INSTR;
        r_if_valid <= 1'b0;
      end
    end else if (bus.flush_i) begin
      r_pc       <= w_pc_plus2;
      r_if_pc    <= '0;
      r_if_pc2   <= '0;
      r_if_instr <= NOP_INSTR;
      r_if_valid <= 1'b0;
    end else begin
      r_pc       <= w_pc_plus2;
      r_if_pc    <= r_pc;
      r_if_pc2   <= w_pc_plus2;
      r_if_instr <= w_instr;
      r_if_valid <= w_in_range;
      if (w_in_range) begin
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      end
    end
  end

  assign bus.pc_o             = r_pc;
  assign bus.if_id_pc_o       = r_if_pc;
  assign bus.if_id_pc_plus2_o = r_if_pc2;
  assign bus.if_id_instr_o    = r_if_instr;
  assign bus.if_id_valid_o    = r_if_valid;
  assign bus.fetch_count_o    = r_fetch_cnt;
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand sequences for
// write collision and asynchronous reset, then randomized traffic vs a model.
module tb_if_stage;
  localparam logic [15:0] NOP = 16'h0000;

  logic clk;
  logic rst;
  if_stage_if #(.DATA_W(16), .IMEM_DEPTH(64)) bus ();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference state.
  logic [15:0] m_mem [64];
  logic [15:0] m_pc, m_ifpc, m_p2, m_instr, m_cnt;
  logic        m_valid;

  typedef struct {
    logic        st, fl, br;
    logic [15:0] tg;
    logic [15:0] pc, ifpc, p2, instr;
    logic        valid;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_ifpc = '0; m_p2 = '0; m_instr = NOP; m_valid = 1'b0; m_cnt = '0;
  endtask

  task automatic model_bubble();
    m_ifpc = '0; m_p2 = '0; m_instr = NOP; m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic fl, input logic br,
                            input logic [15:0] tg, input logic we,
                            input logic [5:0] wa, input logic [15:0] wd);
    int          idx;
    logic        inr;
    logic [15:0] f;
    idx = int'(m_pc) / 2;
    inr = (idx < 64);
    f   = inr ? m_mem[idx] : NOP;
    if (br) begin
      m_pc = tg & 16'hFFFE;
      model_bubble();
    end else if (st) begin
      if (fl) model_bubble();
    end else if (fl) begin
      m_pc = m_pc + 16'd2;
      model_bubble();
    end else begin
      m_ifpc  = m_pc;
      m_p2    = m_pc + 16'd2;
      m_instr = f;
      m_valid = inr;
      if (inr) m_cnt = m_cnt + 16'd1;
      m_pc = m_pc + 16'd2;
    end
    if (we) m_mem[wa] = wd;
  endtask

  task automatic check_model(input string name);
    check16({name, ".pc"},    bus.pc_o,             m_pc);
    check16({name, ".ifpc"},  bus.if_id_pc_o,       m_ifpc);
    check16({name, ".p2"},    bus.if_id_pc_plus2_o, m_p2);
    check16({name, ".instr"}, bus.if_id_instr_o,    m_instr);
    check16({name, ".valid"}, 16'(bus.if_id_valid_o), 16'(m_valid));
    check16({name, ".cnt"},   bus.fetch_count_o,    m_cnt);
  endtask

  // One clock edge with the given inputs; model advanced in step.
  task automatic drive(input logic st, input logic fl, input logic br, input logic [15:0] tg,
                       input logic we, input logic [5:0] wa, input logic [15:0] wd);
    bus.stall_i = st; bus.flush_i = fl; bus.branch_taken_i = br; bus.branch_target_i = tg;
    bus.imem_we_i = we; bus.imem_waddr_i = wa; bus.imem_wdata_i = wd;
    @(posedge clk);
    #1;
    model_edge(st, fl, br, tg, we, wa, wd);
    bus.imem_we_i = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 16'h1111, 1'b1, 16'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0002, 16'h0004, 16'h2222, 1'b1, 16'd2};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0002, 16'h0004, 16'h2222, 1'b1, 16'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0002, 16'h0004, 16'h2222, 1'b1, 16'd2};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 16'h0004, 16'h0006, 16'h3333, 1'b1, 16'd3};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0002, 16'h0004, 16'h2222, 1'b1, 16'd4};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 16'd4};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h0000, 16'h0002, 16'h1111, 1'b1, 16'd5};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd5};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'd5};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 16'h0004, 16'h0006, 16'h3333, 1'b1, 16'd6};

    bus.stall_i = 0; bus.flush_i = 0; bus.branch_taken_i = 0; bus.branch_target_i = '0;
    bus.imem_we_i = 0; bus.imem_waddr_i = '0; bus.imem_wdata_i = '0;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("reset");

    // Preload the whole memory while held in reset.
    for (int i = 0; i < 64; i++) begin
      d = (i < 4) ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
      bus.imem_we_i = 1'b1; bus.imem_waddr_i = 6'(i); bus.imem_wdata_i = d;
      @(posedge clk);
      #1;
      m_mem[i] = d;
    end
    bus.imem_we_i = 1'b0;
    check_model("reset_held");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].st, vecs[i].fl, vecs[i].br, vecs[i].tg, 1'b0, 6'd0, 16'h0);
      check16($sformatf("vec%0d.pc", i),    bus.pc_o,             vecs[i].pc);
      check16($sformatf("vec%0d.ifpc", i),  bus.if_id_pc_o,       vecs[i].ifpc);
      check16($sformatf("vec%0d.p2", i),    bus.if_id_pc_plus2_o, vecs[i].p2);
      check16($sformatf("vec%0d.instr", i), bus.if_id_instr_o,    vecs[i].instr);
      check16($sformatf("vec%0d.valid", i), 16'(bus.if_id_valid_o), 16'(vecs[i].valid));
      check16($sformatf("vec%0d.cnt", i),   bus.fetch_count_o,    vecs[i].cnt);
    end

    // Write to the word being fetched: old data is captured, new data seen later.
    drive(1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 6'd0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 6'd1, 16'hABCD);
    check16("collide.old", bus.if_id_instr_o, 16'h2222);
    drive(1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 6'd0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'h0);
    check16("collide.new", bus.if_id_instr_o, 16'hABCD);
    check_model("collide");

    // Asynchronous reset between edges, then confirm memory survived.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model("async_rst_held");
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'h0);
    check16("retain.w0", bus.if_id_instr_o, 16'h1111);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'h0);
    check16("retain.w1", bus.if_id_instr_o, 16'hABCD);
    check_model("retain");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic st, fl, br, we;
      logic [15:0] tg;
      st = ($urandom_range(0, 99) < 20);
      fl = ($urandom_range(0, 99) < 10);
      br = ($urandom_range(0, 99) < 10);
      we = ($urandom_range(0, 99) < 30);
      tg = ($urandom_range(0, 9) == 0) ? 16'(16'hFF00 | 16'($urandom_range(0, 255)))
                                       : 16'($urandom_range(0, 160));
      drive(st, fl, br, tg, we, 6'($urandom_range(0, 63)), 16'($urandom));
      check_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
